// File: rtl/cbus_pkg.sv
// Shared command encodings, error-stretch length and FSM state type for the cbus initiator.
package cbus_pkg;

    localparam logic CBUS_CMD_RD = 1'b1;
    localparam logic CBUS_CMD_WR = 1'b0;

    // Length of the slave monitor's stretched cbus_access_err pulse.
    localparam int CBUS_ERR_STRETCH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ERRCHK = 2'd2,
        ST_RSP    = 2'd3
    } cbus_state_e;

endpackage

// File: rtl/cbus_mst_wdog.sv
// Master-side watchdog: counts REQ cycles and flags expiry on the LIMIT-th cycle.
// Only built when CBUS_MST_TIMEOUT_EN is defined.
`ifdef CBUS_MST_TIMEOUT_EN
module cbus_mst_wdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [31:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 32'd1;
        end
    end

    assign expire = enable && (count == 32'(LIMIT - 1));

endmodule
`endif

// File: rtl/cbus_mst_ctrl.sv
// cbus initiator: takes one host command at a time, runs it on the cbus and returns data + status.
// Define CBUS_MST_TIMEOUT_EN to add the master watchdog (TO_CYCLES) and the rsp_timeout status.
module cbus_mst_ctrl
    import cbus_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_valid,
    output logic          host_ready,
    input  logic          host_cmd,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_timeout,
    output logic          cbus_m_req,
    output logic          cbus_m_cmd,
    output logic [AW-1:0] cbus_m_addr,
    output logic [DW-1:0] cbus_m_wdata,
    input  logic          cbus_rresp,
    input  logic          cbus_waccept,
    input  logic [DW-1:0] cbus_rdata,
    input  logic          cbus_access_err,
    output logic [1:0]    dbg_state
);

    // Host and response channels: a transfer happens on a rising edge where valid and ready are
    // both high; the initiator of valid keeps it and its payload steady until that edge.

    if (TO_CYCLES < 2) begin : g_bad_to_cycles
        $error("cbus_mst_ctrl: TO_CYCLES must be at least 2");
    end

    cbus_state_e   state, state_nxt;
    logic          cmd_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic          accept;
    logic          done;
    logic          wd_expire;

    assign accept = (state == ST_IDLE) && host_valid && !cbus_access_err;
    // Only the completion matching the issued command counts.
    assign done   = (cmd_q == CBUS_CMD_RD) ? cbus_rresp : cbus_waccept;

`ifdef CBUS_MST_TIMEOUT_EN
    logic to_q;

    cbus_mst_wdog #(
        .LIMIT(TO_CYCLES)
    ) u_wdog (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .enable(state == ST_REQ),
        .expire(wd_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_q <= 1'b0;
        end else if (state == ST_REQ && wd_expire && !done) begin
            to_q <= 1'b1;
        end else if (state == ST_RSP && rsp_ready) begin
            to_q <= 1'b0;
        end
    end

    assign rsp_timeout = to_q;
`else
    assign wd_expire   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        host_ready = 1'b0;
        cbus_m_req = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Hold off new work while a stretched error from a prior access is still high.
                host_ready = !cbus_access_err;
                if (accept) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                cbus_m_req = 1'b1;
                if (done) begin
                    state_nxt = ST_ERRCHK;
                end else if (wd_expire) begin
                    state_nxt = ST_RSP;
                end
            end
            ST_ERRCHK: state_nxt = ST_RSP;
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q   <= CBUS_CMD_WR;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q   <= host_cmd;
                addr_q  <= host_addr;
                wdata_q <= host_wdata;
            end
            case (state)
                ST_REQ: begin
                    if (done) begin
                        rdata_q <= (cmd_q == CBUS_CMD_WR) ? '0 : cbus_rdata;
                    end else if (wd_expire) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                // The monitor registers its error one cycle after completion.
                ST_ERRCHK: err_q <= cbus_access_err;
                ST_RSP: begin
                    if (rsp_ready) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cbus_m_cmd   = cmd_q;
    assign cbus_m_addr  = addr_q;
    assign cbus_m_wdata = wdata_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_cbus_mst_ctrl.sv
// Self-checking bench for cbus_mst_ctrl; the watchdog scenario runs when CBUS_MST_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_cbus_mst_ctrl;
    import cbus_pkg::*;

    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int TO_CYC = 8;
    localparam int W      = DW + 2;
`ifdef CBUS_MST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk, reset;
    logic          host_valid, host_ready, host_cmd;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          cbus_m_req, cbus_m_cmd;
    logic [AW-1:0] cbus_m_addr;
    logic [DW-1:0] cbus_m_wdata;
    logic          cbus_rresp, cbus_waccept, cbus_access_err;
    logic [DW-1:0] cbus_rdata;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        int           n_req;
        int           rsp_lat;
        bit           got_valid;
        logic [W-1:0] rsp;
        bit           fwd_ok;
        bit           stable_ok;
        bit           cleared_ok;
        bit           ready_back;
        int           ready_leak;
        int           acc_wait;
    } obs_t;

    cbus_mst_ctrl #(.AW(AW), .DW(DW), .TO_CYCLES(TO_CYC)) dut (
        .clk(clk), .reset(reset),
        .host_valid(host_valid), .host_ready(host_ready), .host_cmd(host_cmd),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .cbus_m_req(cbus_m_req), .cbus_m_cmd(cbus_m_cmd), .cbus_m_addr(cbus_m_addr),
        .cbus_m_wdata(cbus_m_wdata), .cbus_rresp(cbus_rresp), .cbus_waccept(cbus_waccept),
        .cbus_rdata(cbus_rdata), .cbus_access_err(cbus_access_err), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Reference model: response contents and cycle counts from the transaction description.
    // lat = index of the REQ cycle in which the slave completes (-1 = never).
    function automatic bit model_to(int lat);
        return TO_EN && (lat < 0 || lat >= TO_CYC);
    endfunction

    function automatic logic [W-1:0] model_rsp(logic cmd, logic [DW-1:0] sdata, int lat, bit err);
        logic [DW-1:0] zero;
        zero = '0;
        if (model_to(lat)) return {1'b1, 1'b0, zero};
        return {1'b0, err, (cmd ? sdata : zero)};
    endfunction

    function automatic int model_nreq(int lat);
        return model_to(lat) ? TO_CYC : lat + 1;
    endfunction

    function automatic int model_lat(int lat);
        return model_to(lat) ? TO_CYC : lat + 2;
    endfunction

    // Driver: host side plus slave side for one transaction; records what it saw.
    task automatic drive_txn(input logic cmd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [DW-1:0] sdata, input int lat, input bit raise_err,
                             input int hold, output obs_t o);
        int err_start;
        o.n_req = 0; o.rsp_lat = 0; o.got_valid = 0; o.rsp = '0; o.fwd_ok = 1; o.stable_ok = 1;
        o.cleared_ok = 1; o.ready_back = 0; o.ready_leak = 0; o.acc_wait = 0;
        err_start = 0;
        while (!host_ready && o.acc_wait < 100) begin
            @(negedge clk);
            o.acc_wait++;
        end
        host_valid = 1'b1; host_cmd = cmd; host_addr = addr; host_wdata = wdata;
        @(negedge clk);
        host_valid = 1'b0; host_cmd = 1'($urandom);
        host_addr = AW'($urandom); host_wdata = $urandom;
        while (cbus_m_req && o.n_req < 200) begin
            if (cbus_m_cmd !== cmd || cbus_m_addr !== addr || cbus_m_wdata !== wdata) o.fwd_ok = 0;
            cbus_rresp = 1'b0; cbus_waccept = 1'b0; cbus_rdata = $urandom;
            if (o.n_req == lat) begin
                if (cmd) begin
                    cbus_rresp = 1'b1; cbus_rdata = sdata;
                end else begin
                    cbus_waccept = 1'b1;
                end
            end else if ($urandom_range(0, 1) == 1) begin
                if (cmd) cbus_waccept = 1'b1;
                else     cbus_rresp   = 1'b1;
            end
            o.n_req++;
            @(negedge clk);
        end
        cbus_rresp = 1'b0; cbus_waccept = 1'b0;
        o.rsp_lat = o.n_req;
        if (raise_err) begin
            cbus_access_err = 1'b1;
            err_start = cyc;
        end
        while (!rsp_valid && o.rsp_lat < o.n_req + 4) begin
            @(negedge clk);
            o.rsp_lat++;
        end
        o.got_valid = rsp_valid;
        o.rsp = {rsp_timeout, rsp_err, rsp_rdata};
        for (int h = 0; h < hold; h++) begin
            host_valid = 1'b1; host_cmd = ~cmd;
            @(negedge clk);
            if (!rsp_valid || {rsp_timeout, rsp_err, rsp_rdata} !== o.rsp || cbus_m_req || host_ready)
                o.stable_ok = 0;
        end
        rsp_ready = 1'b1; host_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (rsp_valid || rsp_rdata !== '0 || rsp_err || rsp_timeout || cbus_m_req) o.cleared_ok = 0;
        if (raise_err) begin
            while (cyc - err_start < CBUS_ERR_STRETCH) begin
                if (host_ready || cbus_m_req) o.ready_leak++;
                @(negedge clk);
            end
            cbus_access_err = 1'b0;
            #1;
        end
        o.ready_back = host_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        host_valid = 0; host_cmd = 0; host_addr = '0; host_wdata = '0; rsp_ready = 0;
        cbus_rresp = 0; cbus_waccept = 0; cbus_rdata = '0; cbus_access_err = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cbus_m_req !== 0 || rsp_valid !== 0 || rsp_rdata !== '0 || rsp_err !== 0 || rsp_timeout !== 0 ||
            cbus_m_cmd !== 0 || cbus_m_addr !== '0 || cbus_m_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%0b valid=%0b rdata=%h err=%0b to=%0b addr=%h, required all 0",
                     cbus_m_req, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cbus_m_addr);
        end
        n_checks++;
        if (host_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_idle: host_ready=%0b state=%0d, required 1 / %0d", host_ready, dbg_state, ST_IDLE);
        end
        cbus_access_err = 1'b1;
        #1;
        n_checks++;
        if (host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_err_holdoff: host_ready=%0b, required 0", host_ready);
        end
        cbus_access_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_wait();
        obs_t o;
        logic [W-1:0] exp;
        exp_q.push_back(model_rsp(1'b1, 32'hDEADBEEF, 3, 1'b0));
        drive_txn(1'b1, 16'h0010, 32'h0, 32'hDEADBEEF, 3, 1'b0, 0, o);
        exp = exp_q.pop_front();
        n_checks++;
        if (o.n_req !== 4) begin
            n_fail++; $display("FAIL read_wait_req_cycles: got %0d, required 4", o.n_req);
        end
        n_checks++;
        if (!o.got_valid || o.rsp !== exp) begin
            n_fail++; $display("FAIL read_wait_rsp: valid=%0b rsp=%h, required %h", o.got_valid, o.rsp, exp);
        end
        n_checks++;
        if (!o.fwd_ok || !o.cleared_ok) begin
            n_fail++; $display("FAIL read_wait_bus: fwd_ok=%0b cleared_ok=%0b, required 1/1", o.fwd_ok, o.cleared_ok);
        end
    endtask

    task automatic test_write_zero();
        obs_t o;
        logic [W-1:0] exp;
        logic [AW-1:0] a;
        a = AW'($urandom);
        exp_q.push_back(model_rsp(1'b0, 32'h0, 0, 1'b0));
        drive_txn(1'b0, a, 32'hA5A5A5A5, 32'h0, 0, 1'b0, 0, o);
        exp = exp_q.pop_front();
        n_checks++;
        if (o.n_req !== 1 || o.rsp_lat !== 2) begin
            n_fail++; $display("FAIL write_zero_timing: req=%0d lat=%0d, required 1/2", o.n_req, o.rsp_lat);
        end
        n_checks++;
        if (!o.got_valid || o.rsp !== exp || !o.fwd_ok) begin
            n_fail++; $display("FAIL write_zero_rsp: rsp=%h fwd_ok=%0b, required %h/1", o.rsp, o.fwd_ok, exp);
        end
    endtask

    task automatic test_access_err();
        obs_t o;
        logic [W-1:0] exp;
        logic [DW-1:0] d;
        d = $urandom;
        exp_q.push_back(model_rsp(1'b1, d, 0, 1'b1));
        drive_txn(1'b1, 16'h0200, 32'h0, d, 0, 1'b1, 0, o);
        exp = exp_q.pop_front();
        n_checks++;
        if (!o.got_valid || o.rsp !== exp) begin
            n_fail++; $display("FAIL access_err_rsp: rsp=%h, required %h", o.rsp, exp);
        end
        n_checks++;
        if (o.ready_leak !== 0 || o.ready_back !== 1'b1) begin
            n_fail++; $display("FAIL access_err_holdoff: leaks=%0d ready_after=%0b, required 0/1", o.ready_leak, o.ready_back);
        end
        d = $urandom;
        exp_q.push_back(model_rsp(1'b1, d, 1, 1'b0));
        drive_txn(1'b1, 16'h0204, 32'h0, d, 1, 1'b0, 0, o);
        exp = exp_q.pop_front();
        n_checks++;
        if (o.rsp !== exp || o.acc_wait !== 0) begin
            n_fail++; $display("FAIL after_err_rsp: rsp=%h wait=%0d, required %h/0", o.rsp, o.acc_wait, exp);
        end
    endtask

    task automatic test_rsp_stall();
        obs_t o;
        logic [W-1:0] exp;
        logic [DW-1:0] d;
        d = $urandom;
        exp_q.push_back(model_rsp(1'b1, d, 2, 1'b0));
        drive_txn(1'b1, 16'h0400, 32'h0, d, 2, 1'b0, 10, o);
        exp = exp_q.pop_front();
        n_checks++;
        if (!o.stable_ok) begin
            n_fail++; $display("FAIL rsp_stall_stable: stable_ok=%0b, required 1", o.stable_ok);
        end
        n_checks++;
        if (o.rsp !== exp || !o.cleared_ok) begin
            n_fail++; $display("FAIL rsp_stall_rsp: rsp=%h cleared=%0b, required %h/1", o.rsp, o.cleared_ok, exp);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic [W-1:0] exp;
        logic cmd;
        logic [DW-1:0] d;
        for (int i = 0; i < 4; i++) begin
            cmd = 1'($urandom); d = $urandom;
            exp_q.push_back(model_rsp(cmd, d, 0, 1'b0));
            drive_txn(cmd, AW'($urandom), $urandom, d, 0, 1'b0, 0, o);
            exp = exp_q.pop_front();
            n_checks++;
            if (o.acc_wait !== 0 || o.rsp !== exp || o.rsp_lat !== 2) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: wait=%0d lat=%0d rsp=%h, required 0/2/%h", i, o.acc_wait, o.rsp_lat, o.rsp, exp);
            end
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [W-1:0] exp;
        logic cmd;
        logic [DW-1:0] d;
        int lat, hold;
        bit err;
        for (int i = 0; i < 24; i++) begin
            cmd  = 1'($urandom);
            d    = $urandom;
            lat  = $urandom_range(0, TO_EN ? 10 : 5);
            err  = !model_to(lat) && ($urandom_range(0, 3) == 0);
            hold = $urandom_range(0, 3);
            exp_q.push_back(model_rsp(cmd, d, lat, err));
            drive_txn(cmd, AW'($urandom), $urandom, d, lat, err, hold, o);
            exp = exp_q.pop_front();
            n_checks++;
            if (!o.got_valid || o.rsp !== exp) begin
                n_fail++; $display("FAIL random[%0d]_rsp: valid=%0b rsp=%h, required %h", i, o.got_valid, o.rsp, exp);
            end
            n_checks++;
            if (o.n_req !== model_nreq(lat) || o.rsp_lat !== model_lat(lat)) begin
                n_fail++;
                $display("FAIL random[%0d]_timing: req=%0d lat=%0d, required %0d/%0d", i, o.n_req, o.rsp_lat,
                         model_nreq(lat), model_lat(lat));
            end
            n_checks++;
            if (!o.fwd_ok || !o.stable_ok || !o.cleared_ok || o.ready_leak !== 0 || !o.ready_back) begin
                n_fail++;
                $display("FAIL random[%0d]_flow: fwd=%0b stable=%0b cleared=%0b leaks=%0d ready=%0b, required 1/1/1/0/1",
                         i, o.fwd_ok, o.stable_ok, o.cleared_ok, o.ready_leak, o.ready_back);
            end
        end
    endtask

`ifdef CBUS_MST_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        logic [W-1:0] exp;
        logic [DW-1:0] d;
        int lat_tab[4] = '{-1, 7, -1, 6};
        logic cmd_tab[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            exp_q.push_back(model_rsp(cmd_tab[i], d, lat_tab[i], 1'b0));
            drive_txn(cmd_tab[i], AW'($urandom), $urandom, d, lat_tab[i], 1'b0, 0, o);
            exp = exp_q.pop_front();
            n_checks++;
            if (o.n_req !== model_nreq(lat_tab[i]) || o.rsp_lat !== model_lat(lat_tab[i]) || o.rsp !== exp) begin
                n_fail++;
                $display("FAIL timeout[%0d]: req=%0d lat=%0d rsp=%h, required %0d/%0d/%h", i, o.n_req, o.rsp_lat,
                         o.rsp, model_nreq(lat_tab[i]), model_lat(lat_tab[i]), exp);
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        host_valid = 1'b1; host_cmd = 1'b1; host_addr = 16'h0808; host_wdata = '0;
        @(negedge clk);
        host_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cbus_m_req !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_setup: req=%0b, required 1", cbus_m_req);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (cbus_m_req !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_drop: req=%0b valid=%0b, required 0/0", cbus_m_req, rsp_valid);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cbus_rresp = 1'b1; cbus_rdata = $urandom;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid || cbus_m_req || !host_ready) bad++;
        end
        cbus_rresp = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL reset_mid_quiet: %0d bad cycles, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_read_wait();
        test_write_zero();
        test_access_err();
        test_rsp_stall();
        test_back_to_back();
`ifdef CBUS_MST_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
